boot_cmd_parser: RTL and testbench

- Framed command engine between the UART byte receiver/transmitter and the SoC memories' debug ports (IMEM port B write, DMEM port B read).
- Decodes host frames to load program words into instruction memory and to dump data memory back over the serial link, with per-frame XOR checksum and inter-byte timeout.

---
 rtl/boot_cmd_parser.sv | 228 ++++++++++++++++++++++
 tb/tb_boot_cmd_parser.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_cmd_parser.sv
// Framed host command engine: loads IMEM words and dumps DMEM words over a byte link,
// with a per-frame XOR checksum and an inter-byte timeout.
//
// state   | meaning
// IDLE    | waiting for a command byte (0xA5 write, 0x5A read, 0x01 ping)
// HDR     | collecting ADDR_HI, ADDR_LO, CNT_HI, CNT_LO
// WDATA   | assembling little-endian words and writing them to IMEM
// CSUM    | waiting for the checksum byte
// REPLY   | holding ACK/NAK until the transmitter accepts it
// RD_ADDR | presenting the DMEM word address
// RD_WAIT | capturing DMEM read data
// RD_SEND | streaming the captured word LSB first
module boot_cmd_parser #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  busy
);

  localparam logic [7:0] CMD_WR   = 8'hA5;
  localparam logic [7:0] CMD_RD   = 8'h5A;
  localparam logic [7:0] CMD_PING = 8'h01;
  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;
  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, CSUM, REPLY, RD_ADDR, RD_WAIT, RD_SEND
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            cmd;
  logic [7:0]            csum;
  logic [1:0]            idx;
  logic [7:0]            addr_hi;
  logic [7:0]            cnt_hi;
  logic [15:0]           words_left;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [TW-1:0]         timer;
  logic                  reply_ack;

  logic        rx_state;
  logic        timeout_hit;
  logic        tx_accept;
  logic        csum_ok;
  logic [15:0] hdr_cnt;
  logic [15:0] hdr_addr;

  assign rx_state    = (state == HDR) || (state == WDATA) || (state == CSUM);
  assign timeout_hit = rx_state && !rx_valid && (timer == '0);
  assign tx_accept   = tx_valid && tx_ready;
  assign csum_ok     = (rx_data == csum);
  assign hdr_cnt     = {cnt_hi, rx_data};
  assign hdr_addr    = {addr_hi, rx_data};
  assign busy        = (state != IDLE);
  assign dmem_addr   = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) state_nxt = HDR;
          else if (rx_data == CMD_PING)               state_nxt = CSUM;
        end
      end
      HDR: begin
        if (rx_valid) begin
          if (idx == 2'd3) begin
            if (cmd == CMD_WR && hdr_cnt != 16'd0) state_nxt = WDATA;
            else                                   state_nxt = CSUM;
          end
        end else if (timeout_hit) begin
          state_nxt = REPLY;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          if (idx == 2'd3 && words_left == 16'd1) state_nxt = CSUM;
        end else if (timeout_hit) begin
          state_nxt = REPLY;
        end
      end
      CSUM: begin
        if (rx_valid || timeout_hit) state_nxt = REPLY;
      end
      REPLY: begin
        if (tx_accept) begin
          if (reply_ack && cmd == CMD_RD && words_left != 16'd0) state_nxt = RD_ADDR;
          else                                                   state_nxt = IDLE;
        end
      end
      RD_ADDR: state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_SEND;
      RD_SEND: begin
        if (tx_accept && idx == 2'd3) begin
          if (words_left == 16'd1) state_nxt = IDLE;
          else                     state_nxt = RD_ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Inter-byte timer: reloaded on every byte, counts down only while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (rx_valid && (rx_state || state == IDLE)) begin
      timer <= TW'(TIMEOUT_CYCLES - 1);
    end else if (rx_state && timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd        <= '0;
      csum       <= '0;
      idx        <= '0;
      addr_hi    <= '0;
      cnt_hi     <= '0;
      words_left <= '0;
      addr       <= '0;
      asm_word   <= '0;
      rd_word    <= '0;
      reply_ack  <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd  <= rx_data;
            csum <= rx_data;
            idx  <= 2'd0;
          end
        end
        HDR: begin
          if (rx_valid) begin
            csum <= csum ^ rx_data;
            idx  <= idx + 2'd1;
            case (idx)
              2'd0:    addr_hi    <= rx_data;
              2'd1:    addr       <= hdr_addr[ADDR_WIDTH-1:0];
              2'd2:    cnt_hi     <= rx_data;
              default: words_left <= hdr_cnt;
            endcase
          end
        end
        WDATA: begin
          if (rx_valid) begin
            csum     <= csum ^ rx_data;
            idx      <= idx + 2'd1;
            asm_word <= {rx_data, asm_word[DATA_WIDTH-1:8]};
            if (idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= {rx_data, asm_word[DATA_WIDTH-1:8]};
              addr       <= addr + ADDR_WIDTH'(1);
              words_left <= words_left - 16'd1;
            end
          end
        end
        CSUM: begin
          if (rx_valid) begin
            tx_valid  <= 1'b1;
            tx_data   <= csum_ok ? BYTE_ACK : BYTE_NAK;
            reply_ack <= csum_ok;
          end
        end
        REPLY: begin
          if (tx_accept) tx_valid <= 1'b0;
        end
        RD_WAIT: begin
          rd_word  <= dmem_rdata;
          tx_data  <= dmem_rdata[7:0];
          tx_valid <= 1'b1;
          idx      <= 2'd0;
        end
        RD_SEND: begin
          if (tx_accept) begin
            if (idx == 2'd3) begin
              tx_valid   <= 1'b0;
              addr       <= addr + ADDR_WIDTH'(1);
              words_left <= words_left - 16'd1;
            end else begin
              idx     <= idx + 2'd1;
              rd_word <= rd_word >> 8;
              tx_data <= rd_word[15:8];
            end
          end
        end
        default: ;
      endcase
      if (timeout_hit) begin
        tx_valid  <= 1'b1;
        tx_data   <= BYTE_NAK;
        reply_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_cmd_parser.sv
// Scoreboard bench for boot_cmd_parser: expected TX bytes and IMEM writes are queued
// as frames are driven and retired by monitors as the DUT produces them.
module tb_boot_cmd_parser;

  localparam int AW = 10;
  localparam int TO = 100;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_rdata;
  logic          busy;

  boot_cmd_parser #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int write_seen = 0;
  bit rand_ready = 0;
  bit prev_stall = 0;
  bit prev_we = 0;
  logic [7:0] prev_data;

  logic [7:0]    exp_tx[$];
  logic [AW-1:0] exp_wa[$];
  logic [31:0]   exp_wd[$];
  logic [7:0]    frm[$];
  logic [31:0]   dmem [0:(1<<AW)-1];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dmem_rdata <= dmem[dmem_addr];

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected got=%02h want=none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (tx_data !== e) begin
            failures++;
            $display("FAIL tx_byte got=%02h want=%02h", tx_data, e);
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          failures++;
          $display("FAIL tx_stall_stable got=%b/%02h want=1/%02h", tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (imem_we) begin
        write_seen++;
        checks++;
        if (prev_we) begin
          failures++;
          $display("FAIL imem_we_width got=2+ cycles want=1");
        end
        if (exp_wa.size() == 0) begin
          failures++;
          $display("FAIL imem_unexpected got=%03h/%08h want=none", imem_addr, imem_wdata);
        end else begin
          logic [AW-1:0] ea;
          logic [31:0]   ed;
          ea = exp_wa.pop_front();
          ed = exp_wd.pop_front();
          if (imem_addr !== ea || imem_wdata !== ed || cyc != last_rx_cyc + 1) begin
            failures++;
            $display("FAIL imem_write got=%03h/%08h@%0d want=%03h/%08h@%0d",
                     imem_addr, imem_wdata, cyc, ea, ed, last_rx_cyc + 1);
          end
        end
      end
      prev_we = imem_we;
    end else begin
      prev_stall = 0;
      prev_we    = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data     = b;
    rx_valid    = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] flip);
    logic [7:0] c;
    c = 8'h00;
    foreach (frm[i]) begin
      send_byte(frm[i]);
      c = c ^ frm[i];
    end
    send_byte(c ^ flip);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_tx.size() == 0 && exp_wa.size() == 0 && busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_data, tx_valid, imem_we, imem_addr, imem_wdata, dmem_addr, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%02h/%b/%b/%03h/%08h/%03h/%b want=all0",
               tx_data, tx_valid, imem_we, imem_addr, imem_wdata, dmem_addr, busy);
    end
    rst_n = 1'b1;
    exp_tx.push_back(8'h06);
    send_byte(8'h01);
    send_byte(8'h01);
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL ping_reply_timing got=%b want=1", tx_valid);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ping_done got=busy want=idle"); end
  endtask

  task automatic test_write(input logic [7:0] flip, input logic [7:0] reply);
    bit ok;
    int w0;
    w0 = write_seen;
    exp_wa.push_back(10'h010); exp_wd.push_back(32'h12345678);
    exp_wa.push_back(10'h011); exp_wd.push_back(32'hDEADBEEF);
    exp_tx.push_back(reply);
    frm = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(flip);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== reply) begin
      failures++;
      $display("FAIL write_reply got=%b/%02h want=1/%02h", tx_valid, tx_data, reply);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || write_seen - w0 != 2) begin
      failures++;
      $display("FAIL write_count got=%0d ok=%b want=2", write_seen - w0, ok);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    exp_wa.push_back(10'h3FF); exp_wd.push_back(32'h44332211);
    exp_wa.push_back(10'h000); exp_wd.push_back(32'h88776655);
    exp_tx.push_back(8'h06);
    frm = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(8'h00);
    wait_idle(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_done got=pending want=drained"); end
  endtask

  task automatic test_cnt_zero;
    bit ok;
    int w0;
    w0 = write_seen;
    exp_tx.push_back(8'h06);
    frm = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h00};
    send_frame(8'h00);
    wait_idle(50, ok);
    exp_tx.push_back(8'h06);
    frm = '{8'h5A, 8'h00, 8'h07, 8'h00, 8'h00};
    send_frame(8'h00);
    wait_idle(50, ok);
    checks++;
    if (!ok || write_seen != w0) begin
      failures++;
      $display("FAIL cnt_zero got=writes%0d ok=%b want=writes0 ok=1", write_seen - w0, ok);
    end
  endtask

  task automatic test_ignored;
    send_byte(8'h33);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_cmd got=%b/%b want=0/0", busy, tx_valid);
    end
  endtask

  task automatic test_dmem_read;
    bit ok;
    logic [7:0] seq [9];
    seq = '{8'h06, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h04, 8'h03, 8'h02, 8'h01};
    foreach (seq[i]) exp_tx.push_back(seq[i]);
    rand_ready = 1;
    frm = '{8'h5A, 8'h00, 8'h05, 8'h00, 8'h02};
    send_frame(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b want=1", busy); end
    wait_idle(400, ok);
    rand_ready = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL read_done got=%0d_left want=0", exp_tx.size());
    end
    exp_tx.push_back(8'h15);
    send_frame(8'h01);
    wait_idle(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL read_nak got=pending want=drained"); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n, rise, w0;
    w0 = write_seen;
    rise = -1;
    exp_tx.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    n = last_rx_cyc;
    for (int i = 0; i < 300; i++) begin
      if (tx_valid === 1'b1) begin rise = cyc; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (rise != n + TO + 1) begin
      failures++;
      $display("FAIL timeout_cycle got=%0d want=%0d", rise - n, TO + 1);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || write_seen != w0) begin
      failures++;
      $display("FAIL timeout_idle got=ok%b writes%0d want=ok1 writes0", ok, write_seen - w0);
    end
  endtask

  task automatic test_timeout_tie;
    bit ok;
    exp_tx.push_back(8'h06);
    send_byte(8'h01);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h01);
    wait_idle(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_tie got=pending want=ack"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int w0;
    w0 = write_seen;
    frm = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h78, 8'h56};
    foreach (frm[i]) send_byte(frm[i]);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_valid, imem_we, imem_addr, imem_wdata, dmem_addr, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%02h/%b/%b/%03h/%08h/%03h/%b want=all0",
               tx_data, tx_valid, imem_we, imem_addr, imem_wdata, dmem_addr, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h34);
    send_byte(8'h12);
    repeat (TO + 50) @(posedge clk);
    #1;
    checks++;
    if (write_seen != w0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet got=writes%0d busy%b tx%b want=0/0/0",
               write_seen - w0, busy, tx_valid);
    end
    exp_tx.push_back(8'h06);
    send_byte(8'h01);
    send_byte(8'h01);
    wait_idle(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_ping got=pending want=ack"); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) dmem[i] = 32'h0;
    dmem[5] = 32'hCAFEF00D;
    dmem[6] = 32'h01020304;
    test_reset();
    test_write(8'h00, 8'h06);
    test_write(8'h01, 8'h15);
    test_wrap();
    test_cnt_zero();
    test_ignored();
    test_dmem_read();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    checks++;
    if (exp_tx.size() != 0 || exp_wa.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d/%0d want=0/0", exp_tx.size(), exp_wa.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
